// File: rtl/reg_file_wb_sink.sv
// Architectural register file fed by writeback, two bypassed read ports,
// and a halt-triggered serial register dump with valid/ready handshake.
module reg_file_wb_sink #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [ADDR_W-1:0] p1_addr,
  output logic [DATA_W-1:0] p0,
  output logic [DATA_W-1:0] p1,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] RegData,
  input  logic              hlt,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done
);

  localparam int NREGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREGS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DUMP = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [DATA_W-1:0] regs [NREGS];
  logic [1:0]        state;
  logic [ADDR_W-1:0] idx;
  logic              we;

  assign we = RegWrite &&
              !((ZERO_REG != 0) && (write_addr == '0));

  // Same-cycle writes are forwarded so decode never sees stale data.
  function automatic logic [DATA_W-1:0] rd(
    input logic [ADDR_W-1:0] a
  );
    if ((ZERO_REG != 0) && (a == '0))
      return '0;
    else if (RegWrite && (write_addr == a))
      return RegData;
    else
      return regs[a];
  endfunction

  always_comb begin
    p0 = rd(p0_addr);
    p1 = rd(p1_addr);
  end

  always_comb begin
    dump_valid = (state == DUMP);
    dump_done  = (state == DONE);
    dump_addr  = idx;
    dump_data  = '0;
    if (state == DUMP)
      dump_data = rd(idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (we) begin
      regs[write_addr] <= RegData;
    end
  end

  // Dump ends on the compare against the last index, never on wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hlt) begin
            state <= DUMP;
            idx   <= '0;
          end
        end
        DUMP: begin
          if (dump_ready) begin
            if (idx == LAST) begin
              state <= DONE;
              idx   <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DONE: ;
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_wb_sink.sv
// Bench for reg_file_wb_sink: vector table for the read/write paths,
// hand sequences for reset, dump, backpressure and mid-dump reset.
module tb_reg_file_wb_sink;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  p0_addr, p1_addr, write_addr;
  logic [15:0] p0, p1, RegData;
  logic        RegWrite, hlt, dump_ready;
  logic        dump_valid, dump_done;
  logic [3:0]  dump_addr;
  logic [15:0] dump_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reg_file_wb_sink #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst),
    .p0_addr(p0_addr), .p1_addr(p1_addr),
    .p0(p0), .p1(p1),
    .RegWrite(RegWrite), .write_addr(write_addr), .RegData(RegData),
    .hlt(hlt), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data), .dump_done(dump_done)
  );

  typedef struct {
    logic        wr;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [3:0]  a0;
    logic [3:0]  a1;
    logic [15:0] e0;
    logic [15:0] e1;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    RegWrite = 1'b1; write_addr = a; RegData = d;
    tick();
    RegWrite = 1'b0;
  endtask

  task automatic preload();
    for (int n = 0; n < 16; n++)
      wr(4'(n), 16'(n * 16'h11));
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic start_dump();
    hlt = 1'b1;
    tick();
    hlt = 1'b0;
  endtask

  initial begin
    vt[0] = '{1'b1, 4'd3,  16'h1234, 4'd3,  4'd3, 16'h1234, 16'h1234};
    vt[1] = '{1'b0, 4'd0,  16'h0000, 4'd3,  4'd0, 16'h1234, 16'h0000};
    vt[2] = '{1'b1, 4'd3,  16'h5678, 4'd3,  4'd3, 16'h5678, 16'h5678};
    vt[3] = '{1'b0, 4'd0,  16'h0000, 4'd3,  4'd3, 16'h5678, 16'h5678};
    vt[4] = '{1'b1, 4'd0,  16'hFFFF, 4'd0,  4'd0, 16'h0000, 16'h0000};
    vt[5] = '{1'b0, 4'd0,  16'h0000, 4'd0,  4'd0, 16'h0000, 16'h0000};
    vt[6] = '{1'b1, 4'd15, 16'hABCD, 4'd15, 4'd3, 16'hABCD, 16'h5678};
    vt[7] = '{1'b1, 4'd1,  16'h0001, 4'd15, 4'd1, 16'hABCD, 16'h0001};
    vt[8] = '{1'b0, 4'd0,  16'h0000, 4'd1,  4'd2, 16'h0001, 16'h0000};

    rst = 1'b1; hlt = 1'b0; dump_ready = 1'b0;
    RegWrite = 1'b0; write_addr = '0; RegData = '0;
    p0_addr = '0; p1_addr = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", 32'(dump_valid), 32'd0);
    chk("rst_done",  32'(dump_done),  32'd0);
    chk("rst_addr",  32'(dump_addr),  32'd0);
    chk("rst_data",  32'(dump_data),  32'd0);

    // Reset clears a written register
    wr(4'd5, 16'hBEEF);
    p0_addr = 4'd5;
    #1 chk("r5_pre_rst", 32'(p0), 32'hBEEF);
    pulse_rst();
    chk("r5_post_rst", 32'(p0), 32'h0000);
    chk("done_post_rst", 32'(dump_done), 32'd0);

    foreach (vt[i]) begin
      RegWrite = vt[i].wr; write_addr = vt[i].wa; RegData = vt[i].wd;
      p0_addr = vt[i].a0; p1_addr = vt[i].a1;
      #1;
      chk($sformatf("vec%0d_p0", i), 32'(p0), 32'(vt[i].e0));
      chk($sformatf("vec%0d_p1", i), 32'(p1), 32'(vt[i].e1));
      tick();
    end
    RegWrite = 1'b0;

    // Full dump with ready held high
    pulse_rst();
    preload();
    dump_ready = 1'b1;
    start_dump();
    for (int n = 0; n < 16; n++) begin
      chk($sformatf("dump%0d_valid", n), 32'(dump_valid), 32'd1);
      chk($sformatf("dump%0d_addr", n), 32'(dump_addr), 32'(n));
      chk($sformatf("dump%0d_data", n), 32'(dump_data), 32'(n * 'h11));
      tick();
    end
    chk("dump_done", 32'(dump_done), 32'd1);
    chk("dump_end_valid", 32'(dump_valid), 32'd0);
    start_dump();
    chk("done_hold_hlt", 32'(dump_done), 32'd1);
    chk("done_hold_valid", 32'(dump_valid), 32'd0);

    // Backpressure at idx 7 with a write landing during the stall
    pulse_rst();
    preload();
    dump_ready = 1'b1;
    start_dump();
    for (int n = 0; n < 7; n++) tick();
    chk("bp_addr7", 32'(dump_addr), 32'd7);
    dump_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        RegWrite = 1'b1; write_addr = 4'd7; RegData = 16'hAAAA;
        #1 chk("bp_bypass", 32'(dump_data), 32'hAAAA);
      end
      chk($sformatf("bp_c%0d_valid", c), 32'(dump_valid), 32'd1);
      chk($sformatf("bp_c%0d_addr", c), 32'(dump_addr), 32'd7);
      tick();
      RegWrite = 1'b0;
    end
    chk("bp_data", 32'(dump_data), 32'hAAAA);
    chk("bp_hold_addr", 32'(dump_addr), 32'd7);
    dump_ready = 1'b1;
    tick();
    chk("bp_next_addr", 32'(dump_addr), 32'd8);
    chk("bp_next_data", 32'(dump_data), 32'h0088);
    tick();
    chk("mid_addr9", 32'(dump_addr), 32'd9);

    // Reset mid-dump, then restart
    pulse_rst();
    chk("mid_valid", 32'(dump_valid), 32'd0);
    chk("mid_done", 32'(dump_done), 32'd0);
    chk("mid_addr", 32'(dump_addr), 32'd0);
    p0_addr = 4'd7; p1_addr = 4'd9;
    #1 chk("mid_r7", 32'(p0), 32'h0000);
    chk("mid_r9", 32'(p1), 32'h0000);
    dump_ready = 1'b0;
    start_dump();
    chk("restart_valid", 32'(dump_valid), 32'd1);
    chk("restart_addr", 32'(dump_addr), 32'd0);
    dump_ready = 1'b1;
    tick();
    chk("restart_addr1", 32'(dump_addr), 32'd1);
    chk("restart_data1", 32'(dump_data), 32'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
